// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared definitions for the two-port ram arbiter: sequencer state encodings
// (3-bit, fixed values so the ram-side bench can decode them) and default
// ram geometry.
// ---------------------------------------------------------------------------
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 4;  // 16 words
  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_RDWAIT = 3'd2,
    ST_DONE   = 3'd3,
    ST_INIT   = 3'd4
  } state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the two requester handshakes and the ram pin group.
//   slave  : arbiter view (takes requests and ram_q, drives acks/ram pins)
//   master : environment view (requesters plus the ram itself)
// Requester side : req0/1, we0/1, addr0/1, wdata0/1 -> ack0/1, rdata0/1
// Ram side       : ram_wr, ram_rd, ram_addr, ram_data -> ram_q
// Status         : busy
// ---------------------------------------------------------------------------
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              ram_wr;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    output ack0, ack1, rdata0, rdata1, ram_wr, ram_rd, ram_addr, ram_data, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    input  ack0, ack1, rdata0, rdata1, ram_wr, ram_rd, ram_addr, ram_data, busy
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin grant. The last_grant history register
// lives in the caller.
//   req0_i, req1_i : pending requests
//   last_grant_i   : port granted most recently
//   valid_o        : at least one request pending
//   grant_o        : port to serve (meaningful only when valid_o)
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic grant_o
);

  assign valid_o = req0_i | req1_i;

  // On a tie the port not served last wins; otherwise the lone requester.
  assign grant_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Round-robin arbiter and sequencer in front of a synchronous single-port
// ram. One transaction at a time: IDLE -> ISSUE -> (RDWAIT) -> DONE -> IDLE.
// All ram pins are registered; read data is captured from the ram's
// registered output and returned with a one-cycle ack on the granted port.
//   clk   : system clock, posedge
//   reset : synchronous, active-high
//   bus   : ram_arbiter_if.slave (requester handshakes + ram pins + busy)
// Optional build macro RAM_ARB_INIT_EN: after reset, an INIT sweep writes 0
// to every ram word (one per cycle) before the first request is served.
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

`ifdef RAM_ARB_INIT_EN
  localparam state_e             RESET_STATE = ST_INIT;
  localparam logic               RESET_WR    = 1'b1;
  localparam logic [ADDR_W-1:0]  ADDR_LAST   = '1;
`else
  localparam state_e             RESET_STATE = ST_IDLE;
  localparam logic               RESET_WR    = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              last_grant_q;  // also identifies the port being served
  logic              ram_wr_q;
  logic              ram_rd_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;

  logic              arb_valid;
  logic              arb_grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [1:0]        ack_w;
  logic              busy_w;
  logic [DATA_W-1:0] rdata_w [2];

  rr_arb2 u_rr_arb2 (
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .grant_o      (arb_grant)
  );

  // Request fields are sampled only at grant, so late changes before the
  // grant are honoured.
  assign sel_we    = arb_grant ? bus.we1    : bus.we0;
  assign sel_addr  = arb_grant ? bus.addr1  : bus.addr0;
  assign sel_wdata = arb_grant ? bus.wdata1 : bus.wdata0;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (arb_valid) state_d = ST_ISSUE;
      // ram_wr_q still reflects the issued operation during ISSUE.
      ST_ISSUE:  state_d = ram_wr_q ? ST_DONE : ST_RDWAIT;
      ST_RDWAIT: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
`ifdef RAM_ARB_INIT_EN
      ST_INIT:   if (ram_addr_q == ADDR_LAST) state_d = ST_IDLE;
`else
      ST_INIT:   state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------- ram pin and grant registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;  // port 0 wins the first tie
      ram_wr_q     <= RESET_WR;
      ram_rd_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            last_grant_q <= arb_grant;
            ram_addr_q   <= sel_addr;
            ram_data_q   <= sel_wdata;
            ram_wr_q     <= sel_we;
            ram_rd_q     <= ~sel_we;
          end
        end
        ST_ISSUE: begin
          // Strobes last exactly one cycle; address/data keep their value.
          ram_wr_q <= 1'b0;
          ram_rd_q <= 1'b0;
        end
        ST_INIT: begin
`ifdef RAM_ARB_INIT_EN
          if (ram_addr_q == ADDR_LAST) begin
            ram_wr_q <= 1'b0;
          end else begin
            ram_addr_q <= ram_addr_q + 1'b1;
          end
`else
          ram_wr_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // ---------------- per-port read data capture ----------------
  // ram_q is only trusted in RDWAIT; the ram floats it after writes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q <= '0;
      end else if (state_q == ST_RDWAIT && last_grant_q == 1'(gi)) begin
        rdata_q <= bus.ram_q;
      end
    end
    assign rdata_w[gi] = rdata_q;
  end

  // ---------------- output logic ----------------
  always_comb begin
    ack_w  = 2'b00;
    busy_w = 1'b1;
    if (state_q == ST_IDLE) busy_w = 1'b0;
    if (state_q == ST_DONE) ack_w[last_grant_q] = 1'b1;
  end

  assign bus.ack0     = ack_w[0];
  assign bus.ack1     = ack_w[1];
  assign bus.rdata0   = rdata_w[0];
  assign bus.rdata1   = rdata_w[1];
  assign bus.busy     = busy_w;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.ram_rd   = ram_rd_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_data = ram_data_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the 16x4 synchronous ram block.
- Accepts one read or write request per transaction from either of two requesters and drives the ram's WR/RD/Address/Data pins from registered outputs.
- Captures the ram's registered read data and returns it to the granted requester with a one-cycle ack pulse.

Parameters:
- ADDR_W, 4, ram address width; 2**ADDR_W words.
- DATA_W, 4, ram data width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req0 / req1  input  1  request from requester 0 / 1; held until matching ack.
- we0 / we1  input  1  1 = write, 0 = read; stable while req high.
- addr0 / addr1  input  ADDR_W  word address; stable while req high.
- wdata0 / wdata1  input  DATA_W  write data; stable while req high.
- ack0 / ack1  output  1  one-cycle completion pulse.
- rdata0 / rdata1  output  DATA_W  read result; valid while ack high, held until next read for that port.
- ram_wr  output  1  to ram WR.
- ram_rd  output  1  to ram RD.
- ram_addr  output  ADDR_W  to ram Address.
- ram_data  output  DATA_W  to ram Data.
- ram_q  input  DATA_W  from ram Out.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=1 so port 0 wins the first tie.
- Reset mid-transaction aborts it with no ack. A write already sampled by the ram stays written.
- FSM states: IDLE, ISSUE, RDWAIT, DONE (plus INIT with the optional feature).
- IDLE: at a clk edge with any req high, choose the grant, register ram_addr/ram_data from the granted port, set ram_wr=we or ram_rd=!we, and go to ISSUE.
- Arbitration:
  - Only one req high: grant that port.
  - Both high: grant !last_grant.
  - last_grant updates on every grant.
- ISSUE: ram pins valid for exactly this cycle; the ram executes at its end.
  - Next edge: ram_wr=ram_rd=0.
  - Write goes to DONE; read goes to RDWAIT.
- RDWAIT: ram_q is valid this cycle. Next edge: latch ram_q into rdata of the granted port, go to DONE.
- DONE: ack of the granted port = 1 for this cycle only. Next edge: IDLE. The requester must drop or change req at the end of DONE.
- Latency from the edge that samples req to the ack cycle:
  - Write: 2 cycles; back-to-back throughput 3 cycles.
  - Read: 3 cycles; back-to-back throughput 4 cycles.
- Requests arriving outside IDLE wait; they are never dropped.
- ram_wr and ram_rd are never both 1. ram_addr/ram_data hold their values outside ISSUE.
- ram_q is ignored outside RDWAIT; the ram tristates Q after a write-only access.
- A port with req continuously high alternates grants with the other port and never starves it.
- addr/wdata/we changes while req is high and not yet granted take effect at grant.

Optional Feature:
- Macro: RAM_ARB_INIT_EN.
- Defined:
  - After reset, state INIT sweeps addresses 0..2**ADDR_W-1, one per cycle, with ram_wr=1 and ram_data=0.
  - busy=1 throughout; requests are held pending.
  - Goes to IDLE the cycle after the last address is issued: 16 INIT cycles at default parameters.
  - Reset during INIT restarts the sweep at 0.
- Undefined: reset goes directly to IDLE; ram contents are unknown until written.

Decomposition:
- Shared include ram_ctrl_defs.vh holds the state encodings (IDLE=0, ISSUE=1, RDWAIT=2, DONE=3, INIT=4; 3-bit state) and default ADDR_W/DATA_W. The ram and its testbench share it.
- One sub-module: rr_arb2, a combinational 2-way round-robin grant from (req0, req1, last_grant). The last_grant register stays in ram_arbiter.

Test Plan:
- Port 0 writes addr 3 data 4'hA, then reads addr 3 -> ack0 2 cycles after write acceptance; ack0 3 cycles after read acceptance with rdata0=4'hA; ack1 never high.
- req0 and req1 both rise together (reads of addr 1 and 2) after reset -> port 0 granted first, port 1 second; at most one ack per cycle.
- req0 held high continuously plus a single req1 -> grants alternate 0,1,0; req1 acked within 8 cycles.
- Assert reset in ISSUE of a write to addr 5 data 4'h7 -> no ack, outputs 0 next cycle; a later read of addr 5 returns 4'h7.
- Monitor the whole run -> ram_wr&ram_rd never 1; ack width is always exactly 1 cycle; busy low only in IDLE.
- RAM_ARB_INIT_EN defined: hold req0 read of addr 9 from reset release -> busy high 16 cycles, then ack0 with rdata0=4'h0.
